div_unit: RTL
=============

Name: div_unit

Overview:
- Iterative RV32M divide/remainder unit for DIV, DIVU, REM and REMU.
- Sits directly downstream of the register unit: it consumes the rs1/rs2 read data.
- Feeds the register-unit write port with a result, a destination tag and a write strobe.
- Radix-2 restoring algorithm, one quotient bit per clock; a start/busy/done handshake lets control stall the core while a divide runs.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must hold 0..XLEN.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  operation code: 00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0] of 100..111).
- op_a  input  32  dividend (register rs1 read data).
- op_b  input  32  divisor (register rs2 read data).
- rd_in  input  5  destination register index.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle result-valid pulse.
- result  output  32  quotient or remainder.
- rd_out  output  5  captured destination index.
- ru_wr  output  1  write strobe for the register unit: done AND (rd_out != 0).

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; busy=0, done=0, ru_wr=0, result=0, rd_out=0.
  - Counter and internal registers are cleared.
  - Reset wins over any operation in progress; no done is produced for an aborted operation.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1 at edge E0:
  - Latch op and rd_in.
  - Signed ops (00, 10): latch |op_a| and |op_b|, plus sign_q = a[31]^b[31] and sign_r = a[31].
  - Unsigned ops: latch operands raw, with sign_q = sign_r = 0.
  - Special cases, decided from the raw inputs at E0:
    - Divide by zero (op_b==0): quotient=0xFFFFFFFF, remainder=op_a.
    - Signed overflow (op 00/10, op_a=0x80000000, op_b=0xFFFFFFFF): quotient=0x80000000, remainder=0.
    - Either case loads result directly and goes to DONE; done is high in the cycle after E0.
  - Otherwise clear remainder reg R=0, quotient reg Q=dividend, count=0, and go to CALC.
- CALC, one iteration per edge:
  - Form the 33-bit trial value {R,Q[31]} - {0,divisor}.
  - If non-negative, R takes the trial difference and the quotient bit is 1; else R={R[30:0],Q[31]} and the bit is 0.
  - Q shifts left with the new bit inserted at Q[0].
  - count increments; after the 32nd iteration (edge E32) go to FIX.
- FIX (edge E33):
  - result = op DIV/DIVU ? (sign_q ? -Q : Q) : (sign_r ? -R : R).
  - Arithmetic is two's complement, truncated to 32 bits. Go to DONE.
- DONE:
  - done=1 for exactly one cycle; ru_wr per the rule above; next edge goes to IDLE.
  - Normal latency: done is visible in the cycle after E33, i.e. 34 cycles of busy.
- Holding and ignoring:
  - result and rd_out hold their values until the next accepted start or reset.
  - start in CALC/FIX/DONE is ignored; there is no queueing.
  - A start in the same cycle as done is also ignored; control must re-present it once busy=0.
- Remainder sign follows the dividend, quotient truncates toward zero (RISC-V semantics). Operand inputs may change after E0 without effect.

Test Plan:
- DIVU 100/7, rd_in=5 -> after 34 busy cycles: done=1 for 1 cycle, result=14, rd_out=5, ru_wr=1; repeat with REMU -> result=2.
- DIV 0xFFFFFFF9 (-7) / 2 -> result=0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF.
- Divide by zero:
  - DIVU 5/0 -> done on the cycle after start, result=0xFFFFFFFF.
  - REM 5/0 -> result=5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- rd_in=0 with DIV 9/3 -> done=1, result=3, ru_wr=0.
- start pulsed during CALC with different operands -> ignored; the original result is produced at the original time.
- rst_n=0 at iteration 10 -> next cycle busy=0, done=0, result=0; a new DIVU 8/2 then completes normally with result=4.

Source files
------------

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
//
// Purpose:
//   Computes the quotient or remainder of two 32-bit register operands, one
//   quotient bit per clock. Divide-by-zero and signed overflow short-cut
//   straight to DONE. Normal operations hold busy for 34 cycles.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   synchronous active-low reset
//   start   in   request, sampled only in IDLE
//   op      in   00 DIV, 01 DIVU, 10 REM, 11 REMU
//   op_a    in   dividend (rs1 read data)
//   op_b    in   divisor  (rs2 read data)
//   rd_in   in   destination register index
//   busy    out  high whenever the unit is not IDLE
//   done    out  one-cycle result-valid pulse
//   result  out  quotient or remainder, held until the next accepted start
//   rd_out  out  captured destination index
//   ru_wr   out  register-unit write strobe (done with a non-zero rd_out)

module div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            ru_wr
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t            state_q;
  logic              rem_sel_q;
  logic              sign_q_q;
  logic              sign_r_q;
  logic [XLEN-1:0]   dvs_q;
  logic [XLEN-1:0]   rem_q;
  logic [XLEN-1:0]   quo_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   result_q;
  logic [4:0]        rd_q;

  // Decode of the raw inputs at the accepting edge.
  logic              is_signed;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   abs_a;
  logic [XLEN-1:0]   abs_b;
  logic              div_zero;
  logic              sgn_ovf;

  assign is_signed = ~op[0];
  assign a_neg     = is_signed & op_a[XLEN-1];
  assign b_neg     = is_signed & op_b[XLEN-1];
  assign abs_a     = a_neg ? -op_a : op_a;
  assign abs_b     = b_neg ? -op_b : op_b;
  assign div_zero  = (op_b == '0);
  assign sgn_ovf   = is_signed && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);

  // One restoring step: the top bit of the trial difference is the borrow,
  // so a clear borrow means the divisor fits and the quotient bit is 1.
  logic [XLEN:0]     trial_d;
  logic [XLEN-1:0]   rem_d;
  logic [XLEN-1:0]   quo_d;
  logic [XLEN-1:0]   fix_d;

  assign trial_d = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
  assign rem_d   = trial_d[XLEN] ? {rem_q[XLEN-2:0], quo_q[XLEN-1]} : trial_d[XLEN-1:0];
  assign quo_d   = {quo_q[XLEN-2:0], ~trial_d[XLEN]};
  assign fix_d   = rem_sel_q ? (sign_r_q ? -rem_q : rem_q)
                             : (sign_q_q ? -quo_q : quo_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rem_sel_q <= 1'b0;
      sign_q_q  <= 1'b0;
      sign_r_q  <= 1'b0;
      dvs_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      rd_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            rem_sel_q <= op[1];
            rd_q      <= rd_in;
            sign_q_q  <= a_neg ^ b_neg;
            sign_r_q  <= a_neg;
            dvs_q     <= abs_b;
            rem_q     <= '0;
            quo_q     <= abs_a;
            cnt_q     <= '0;
            if (div_zero) begin
              result_q <= op[1] ? op_a : '1;
              state_q  <= S_DONE;
            end else if (sgn_ovf) begin
              result_q <= op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
              state_q  <= S_DONE;
            end else begin
              state_q  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN-1)) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          result_q <= fix_d;
          state_q  <= S_DONE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign rd_out = rd_q;
  assign ru_wr  = done && (rd_q != 5'd0);

endmodule
